qam_modulator: RTL and testbench
================================

Name: qam_modulator

Overview:
- 4-QAM (QPSK) baseband-to-carrier modulator: 2-bit symbols mix a quadrature sine/cosine carrier produced from an internal ROM.
- Emits the modulated sample plus both raw carrier samples as 8-bit offset-binary values, for a DAC or downstream DSP.
- Also emits a carrier-rate square wave (`clk_out`) that marks symbol boundaries.
- Module name `qam_modulator` is the wrapper-free RTL name; the system-level instance is `modulator`.

Parameters:
- `LUT_DEPTH`, 64: carrier samples per period. Power of two, at least 8.
- `CLK_DIV`, 1: system clocks per carrier sample. Must be 1 or more.
- `DW`, 8: sample width. Fixed at 8 in this revision.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `data_in` in 2: QAM symbol. Bit1 selects I, bit0 selects Q.
- `data_modulated` out 8: modulated sample, offset binary with midscale 128.
- `sin_out` out 8: carrier sine sample, offset binary.
- `cos_out` out 8: carrier cosine sample, offset binary.
- `clk_out` out 1: symbol/carrier clock, high for the first half of each carrier period.

Behaviour:
- Reset (`rst`=0 at a `clk` edge):
  - Phase index p=0, divider count 0, latched symbol sym=0.
  - `sin_out`=`cos_out`=`data_modulated`=128, `clk_out`=0.
- Tick generation:
  - A divider counter runs 0..`CLK_DIV`-1.
  - `tick`=1 when the count equals `CLK_DIV`-1.
  - With `CLK_DIV`=1, `tick` is high every cycle after reset.
- On each clock with `tick` and `rst`=1, all updates are registered:
  - p <= (p+1) mod `LUT_DEPTH` (natural wrap).
  - `sin_out` <= SIN[p]; `cos_out` <= COS[p].
  - `clk_out` <= (p < `LUT_DEPTH`/2).
  - Let s = (p==0) ? `data_in` : sym. If p==0, sym <= `data_in`.
  - `data_modulated` <= 128 + ((I*c + Q*sn) >>> 1), where:
    - c = COS[p]-128 and sn = SIN[p]-128, both signed in -127..127;
    - I = s[1] ? +1 : -1; Q = s[0] ? +1 : -1;
    - the sum is computed at 10-bit signed width or wider, and >>> is an arithmetic (floor) shift.
- Latency: outputs lag p by exactly one sample tick.
- Symbol timing:
  - `data_in` is sampled only at p==0, so symbols change only on carrier-period boundaries.
  - Mid-period changes of `data_in` have no effect until the next wrap.
  - The new symbol applies to the p==0 sample itself.
- ROM contents, with N=`LUT_DEPTH`:
  - SIN[k] = 128 + round(127·sin(2πk/N)).
  - COS[k] = 128 + round(127·cos(2πk/N)).
  - Values lie in 1..255, so there is no overflow.
- Range: max |I·c+Q·sn| is about 180, so the output stays in 38..218 and never saturates.
- Without ticks, all outputs hold.
- Reset asserted mid-period: next edge returns to the reset values and sym is discarded. Restart begins at p=0 with a fresh `data_in` sample.
- No handshake: `data_in` is free-running and must be stable only at the p==0 tick edge.

Decomposition:
- Package `qam_pkg` holds:
  - `DW`, `MIDSCALE`=128, `AMP`=127;
  - typedef `sample_t` (8-bit unsigned) and `signed_sample_t` (9-bit signed);
  - a constant function that builds the sine table.
- One sub-module, `qam_sin_rom`: combinational quadrature ROM. Input index p; outputs SIN[p] and COS[p], with COS[p] = SIN[(p+N/4) mod N].
- The top level holds the divider, phase counter, symbol latch, mixer and output registers.

Test Plan:
- Reset held low 5000 cycles -> `sin_out`=`cos_out`=`data_modulated`=128 and `clk_out`=0 throughout. Release -> the first tick produces `sin_out`=128, `cos_out`=255, `clk_out`=1.
- Default params, `data_in`=3 -> at p=0,8,16,32 the outputs are 191, 218, 191, 64. `clk_out` period is 64 cycles with 50% duty.
- `data_in`=0 -> sample at p=0 is 64, at p=16 is 64, at p=8 is 38. `data_in`=2 -> p=0 gives 191, p=16 gives 64.
- Change `data_in` from 0 to 1 at p=20 -> the rest of that period follows symbol 0. The new symbol takes effect exactly at the next p=0 sample.
- `CLK_DIV`=4 -> outputs update every 4th clock and the carrier period is 256 clocks. Assert reset mid-period -> everything returns to 128/0 on the next edge.
- Free run for 1,000,000 cycles with `data_in` incrementing every 1000 cycles -> no output outside 38..218. `sin_out`²+`cos_out`² (centred) is within 127²±256 at every sample.

Source files
------------

// File: rtl/qam_modulator_pkg.sv
// ---------------------------------------------------------------------------
// qam_pkg
// Shared constants, sample types and the sine-table builder for the 4-QAM
// modulator.
//   DW              : sample width (8 bits, offset binary)
//   MIDSCALE        : offset-binary zero level (128)
//   AMP             : carrier amplitude around midscale (127)
//   sample_t        : 8-bit unsigned sample
//   signed_sample_t : 9-bit signed sample, wide enough for (sample - 128)
//   build_sin_entry : elaboration-time constant function returning
//                     128 + round(127*sin(2*pi*k/n))
// ---------------------------------------------------------------------------
package qam_pkg;

    localparam int DW       = 8;
    localparam int MIDSCALE = 128;
    localparam int AMP      = 127;

    typedef logic [DW-1:0]        sample_t;
    typedef logic signed [DW:0]   signed_sample_t;

    // round(pi/2 * 2^30); the table builder works in Q30 fixed point so it
    // needs no real arithmetic.
    localparam longint PI_2_Q30 = 64'sd1686629713;

    // 127*sin(pi/2 * r/qlen), rounded to nearest, for 0 <= r <= qlen.
    // Eight Taylor terms keep the error far below the rounding margin.
    function automatic int quarter_sine(input int r, input int qlen);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (longint'(r) * PI_2_Q30) / longint'(qlen);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int i = 1; i < 8; i++) begin
            term = -((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
            acc  = acc + term;
        end
        return int'((acc * longint'(AMP) + (longint'(1) <<< 29)) >>> 30);
    endfunction

    // One full-period table entry, folded from the first quadrant so the
    // table is exactly odd/even symmetric.
    function automatic sample_t build_sin_entry(input int k, input int n);
        int qlen;
        int quad;
        int r;
        int v;
        qlen = n / 4;
        quad = k / qlen;
        r    = k % qlen;
        case (quad)
            0:       v =  quarter_sine(r, qlen);
            1:       v =  quarter_sine(qlen - r, qlen);
            2:       v = -quarter_sine(r, qlen);
            default: v = -quarter_sine(qlen - r, qlen);
        endcase
        return sample_t'(MIDSCALE + v);
    endfunction

endpackage

// File: rtl/qam_modulator_if.sv
// ---------------------------------------------------------------------------
// qam_modulator_if
// Symbol input and sample outputs of the 4-QAM modulator.
//   data_in        : 2-bit symbol, bit1 selects I sign, bit0 selects Q sign
//   data_modulated : modulated sample, offset binary
//   sin_out        : carrier sine sample, offset binary
//   cos_out        : carrier cosine sample, offset binary
//   clk_out        : high during the first half of each carrier period
// master drives the symbol, slave (the modulator) drives the samples.
// ---------------------------------------------------------------------------
interface qam_modulator_if;
    import qam_pkg::*;

    logic [1:0] data_in;
    sample_t    data_modulated;
    sample_t    sin_out;
    sample_t    cos_out;
    logic       clk_out;

    modport master (
        output data_in,
        input  data_modulated,
        input  sin_out,
        input  cos_out,
        input  clk_out
    );

    modport slave (
        input  data_in,
        output data_modulated,
        output sin_out,
        output cos_out,
        output clk_out
    );

endinterface

// File: rtl/qam_sin_rom.sv
// ---------------------------------------------------------------------------
// qam_sin_rom
// Combinational quadrature carrier ROM.
//   p       : phase index 0..LUT_DEPTH-1
//   sin_val : SIN[p] = 128 + round(127*sin(2*pi*p/N))
//   cos_val : COS[p] = SIN[(p + N/4) mod N]
// ---------------------------------------------------------------------------
module qam_sin_rom
    import qam_pkg::*;
#(
    parameter int LUT_DEPTH = 64
) (
    input  logic [$clog2(LUT_DEPTH)-1:0] p,
    output sample_t                      sin_val,
    output sample_t                      cos_val
);

    localparam int AW = $clog2(LUT_DEPTH);

    sample_t        sin_table [LUT_DEPTH];
    logic [AW-1:0]  cos_idx;

    // Every entry is an elaboration-time constant.
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
        localparam sample_t ENTRY = build_sin_entry(k, LUT_DEPTH);
        assign sin_table[k] = ENTRY;
    end

    // Cosine is the sine a quarter period ahead; the AW-bit add wraps mod N.
    assign cos_idx = p + AW'(LUT_DEPTH / 4);
    assign sin_val = sin_table[p];
    assign cos_val = sin_table[cos_idx];

endmodule

// File: rtl/qam_modulator.sv
// ---------------------------------------------------------------------------
// qam_modulator
// 4-QAM (QPSK) modulator: mixes a latched 2-bit symbol onto a quadrature
// carrier read from qam_sin_rom and registers all outputs.
//   clk : system clock, rising edge
//   rst : synchronous, active-low reset
//   bus : qam_modulator_if.slave (data_in in; data_modulated, sin_out,
//         cos_out, clk_out out)
// Outputs update once per sample tick (every CLK_DIV clocks) and lag the
// phase counter by one tick.
// ---------------------------------------------------------------------------
module qam_modulator
    import qam_pkg::*;
#(
    parameter int LUT_DEPTH = 64,
    parameter int CLK_DIV   = 1,
    parameter int DW        = qam_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    qam_modulator_if.slave  bus
);

    localparam int AW    = $clog2(LUT_DEPTH);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] div_q,     div_d;
    logic [AW-1:0]    phase_q,   phase_d;
    logic [1:0]       sym_q,     sym_d;
    logic [DW-1:0]    sin_q,     sin_d;
    logic [DW-1:0]    cos_q,     cos_d;
    logic [DW-1:0]    mod_q,     mod_d;
    logic             clk_out_q, clk_out_d;

    logic             tick;
    sample_t          rom_sin;
    sample_t          rom_cos;
    logic [1:0]       sym_now;
    signed_sample_t   c_centred;
    signed_sample_t   s_centred;
    logic signed [9:0] i_term;
    logic signed [9:0] q_term;
    logic signed [9:0] mix_sum;
    logic signed [9:0] mix_half;

    qam_sin_rom #(
        .LUT_DEPTH (LUT_DEPTH)
    ) u_rom (
        .p       (phase_q),
        .sin_val (rom_sin),
        .cos_val (rom_cos)
    );

    // Divider, symbol selection, mixer and next-state for all registers.
    always_comb begin
        tick = (div_q == CNT_W'(CLK_DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;

        // A fresh symbol is taken at p==0 and applies to that sample itself.
        sym_now = (phase_q == '0) ? bus.data_in : sym_q;

        c_centred = signed_sample_t'({1'b0, rom_cos}) - signed_sample_t'(MIDSCALE);
        s_centred = signed_sample_t'({1'b0, rom_sin}) - signed_sample_t'(MIDSCALE);

        i_term = 10'(c_centred);
        if (!sym_now[1]) begin
            i_term = -i_term;
        end
        q_term = 10'(s_centred);
        if (!sym_now[0]) begin
            q_term = -q_term;
        end

        // |sum| <= ~180 fits 10 bits; the halved result stays within 38..218.
        mix_sum  = i_term + q_term;
        mix_half = mix_sum >>> 1;

        phase_d   = phase_q;
        sym_d     = sym_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        mod_d     = mod_q;
        clk_out_d = clk_out_q;

        if (tick) begin
            phase_d   = phase_q + 1'b1;
            sym_d     = sym_now;
            sin_d     = rom_sin;
            cos_d     = rom_cos;
            mod_d     = DW'(mix_half + 10'sd128);
            clk_out_d = ~phase_q[AW-1];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q     <= '0;
            phase_q   <= '0;
            sym_q     <= '0;
            sin_q     <= DW'(MIDSCALE);
            cos_q     <= DW'(MIDSCALE);
            mod_q     <= DW'(MIDSCALE);
            clk_out_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            phase_q   <= phase_d;
            sym_q     <= sym_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            mod_q     <= mod_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign bus.sin_out        = sin_q;
    assign bus.cos_out        = cos_q;
    assign bus.data_modulated = mod_q;
    assign bus.clk_out        = clk_out_q;

endmodule

// File: tb/tb_qam_modulator.sv
// ---------------------------------------------------------------------------
// tb_qam_modulator
// Scoreboard bench for two modulators sharing one clock: one with the
// default divider, one with CLK_DIV=4. Expected samples are pushed with the
// absolute clock edge at which they must appear; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_qam_modulator;
    import qam_pkg::*;

    typedef struct {
        int         n;
        logic [7:0] sin_v;
        logic [7:0] cos_v;
        logic [7:0] mod_v;
        logic       clk_v;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic a_live;
    int   cyc = 0;

    int checks      = 0;
    int passed      = 0;
    int reset_bad   = 0;
    int range_bad   = 0;
    int circle_bad  = 0;
    int stress_cnt  = 0;
    int base_a;
    int base_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t e;

    qam_modulator_if bus_a ();
    qam_modulator_if bus_b ();

    qam_modulator #(.LUT_DEPTH(64), .CLK_DIV(1), .DW(8)) modulator (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    qam_modulator #(.LUT_DEPTH(64), .CLK_DIV(4), .DW(8)) modulator_div4 (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // Absolute edge counter; expectations are keyed to it.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [7:0] as, input logic [7:0] ac,
                               input logic [7:0] am, input logic ak, input exp_t x);
        checks++;
        if (as === x.sin_v && ac === x.cos_v && am === x.mod_v && ak === x.clk_v) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s @edge %0d: got sin=%0d cos=%0d mod=%0d clk_out=%0b, expected sin=%0d cos=%0d mod=%0d clk_out=%0b",
                     name, cyc, as, ac, am, ak, x.sin_v, x.cos_v, x.mod_v, x.clk_v);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int required);
        checks++;
        if (actual == required) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input bit which, input logic [1:0] d);
        if (which) bus_b.data_in = d;
        else       bus_a.data_in = d;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic push(input bit which, input int n, input int s, input int c, input int m,
                        input logic k, input string name);
        exp_t x;
        x.n = n; x.sin_v = 8'(s); x.cos_v = 8'(c); x.mod_v = 8'(m); x.clk_v = k; x.name = name;
        if (which) qb.push_back(x);
        else       qa.push_back(x);
    endtask

    // Monitor: sample 1 time unit after each edge, pop due entries, and keep
    // running reset / range / carrier-circle tallies for the default DUT.
    always @(posedge clk) begin
        #1;
        while (qa.size() > 0 && qa[0].n <= cyc) begin
            e = qa.pop_front();
            if (e.n < cyc) begin
                checkCount({e.name, "_missed"}, cyc, e.n);
            end else begin
                checkOutput(e.name, bus_a.sin_out, bus_a.cos_out, bus_a.data_modulated, bus_a.clk_out, e);
            end
        end
        while (qb.size() > 0 && qb[0].n <= cyc) begin
            e = qb.pop_front();
            if (e.n < cyc) begin
                checkCount({e.name, "_missed"}, cyc, e.n);
            end else begin
                checkOutput(e.name, bus_b.sin_out, bus_b.cos_out, bus_b.data_modulated, bus_b.clk_out, e);
            end
        end
        if (cyc >= 1 && rst_a == 1'b0) begin
            if (bus_a.sin_out !== 8'd128 || bus_a.cos_out !== 8'd128 ||
                bus_a.data_modulated !== 8'd128 || bus_a.clk_out !== 1'b0) begin
                reset_bad++;
            end
        end
        if (a_live) begin
            int sc;
            int cc;
            int r2;
            stress_cnt++;
            if (bus_a.data_modulated < 8'd38 || bus_a.data_modulated > 8'd218) begin
                range_bad++;
            end
            sc = int'(bus_a.sin_out) - 128;
            cc = int'(bus_a.cos_out) - 128;
            r2 = sc * sc + cc * cc;
            if (r2 < 16129 - 256 || r2 > 16129 + 256) begin
                circle_bad++;
            end
        end
    end

    initial begin
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        a_live = 1'b0;
        applyStimulus(0, 2'd3);
        applyStimulus(1, 2'd3);

        // Long reset, then release the default-divider DUT.
        repeat (5000) @(negedge clk);
        base_a = cyc;
        // Edge n after release carries phase p = n-1 (mod 64).
        push(0, base_a + 1,   128, 255, 191, 1'b1, "s3_p0");
        push(0, base_a + 9,   218, 218, 218, 1'b1, "s3_p8");
        push(0, base_a + 17,  255, 128, 191, 1'b1, "s3_p16");
        push(0, base_a + 32,  140,   2,  71, 1'b1, "s3_p31");
        push(0, base_a + 33,  128,   1,  64, 1'b0, "s3_p32");
        push(0, base_a + 64,  116, 254, 185, 1'b0, "s3_p63");
        push(0, base_a + 65,  128, 255,  64, 1'b1, "s0_p0");
        push(0, base_a + 73,  218, 218,  38, 1'b1, "s0_p8");
        push(0, base_a + 81,  255, 128,  64, 1'b1, "s0_p16");
        push(0, base_a + 129, 128, 255, 191, 1'b1, "s2_p0");
        push(0, base_a + 145, 255, 128,  64, 1'b1, "s2_p16");
        push(0, base_a + 217, 218,  38, 128, 1'b1, "midchg_p24");
        push(0, base_a + 256, 116, 254,  71, 1'b0, "midchg_p63");
        push(0, base_a + 257, 128, 255,  64, 1'b1, "s1_p0");
        push(0, base_a + 273, 255, 128, 191, 1'b1, "s1_p16");
        rst_a  = 1'b1;
        a_live = 1'b1;

        waitUntil(base_a + 40);  applyStimulus(0, 2'd0);
        waitUntil(base_a + 100); applyStimulus(0, 2'd2);
        waitUntil(base_a + 170); applyStimulus(0, 2'd0);
        // Mid-period change right after the p=20 sample.
        waitUntil(base_a + 213); applyStimulus(0, 2'd1);

        // Free run with a slowly stepping symbol.
        for (int k = 0; k < 18; k++) begin
            waitUntil(base_a + 300 + 1000 * k);
            applyStimulus(0, 2'(k));
        end
        waitUntil(base_a + 18300);

        // Divide-by-4 DUT: first tick lands on the 4th edge after release.
        base_b = cyc;
        push(1, base_b + 3,   128, 128, 128, 1'b0, "div4_pretick");
        push(1, base_b + 4,   128, 255, 191, 1'b1, "div4_p0");
        push(1, base_b + 7,   128, 255, 191, 1'b1, "div4_hold");
        push(1, base_b + 8,   140, 254, 197, 1'b1, "div4_p1");
        push(1, base_b + 131, 140,   2,  71, 1'b1, "div4_p31");
        push(1, base_b + 132, 128,   1,  64, 1'b0, "div4_p32");
        push(1, base_b + 151, 128, 128, 128, 1'b0, "div4_midreset");
        push(1, base_b + 154, 128, 128, 128, 1'b0, "div4_restart_wait");
        push(1, base_b + 155, 128, 255,  64, 1'b1, "div4_restart_p0");
        push(1, base_b + 159, 140, 254,  59, 1'b1, "div4_restart_p1");
        push(1, base_b + 410, 116, 254,  71, 1'b0, "div4_p63");
        push(1, base_b + 411, 128, 255,  64, 1'b1, "div4_wrap_p0");
        rst_b = 1'b1;

        waitUntil(base_b + 150);
        rst_b = 1'b0;
        applyStimulus(1, 2'd0);
        waitUntil(base_b + 151);
        rst_b = 1'b1;
        waitUntil(base_b + 420);

        checkCount("reset_hold_bad_samples", reset_bad, 0);
        checkCount("range_violations", range_bad, 0);
        checkCount("carrier_circle_violations", circle_bad, 0);
        checkCount("stress_samples", stress_cnt, base_b + 420 - base_a);
        checkCount("queue_a_leftover", qa.size(), 0);
        checkCount("queue_b_leftover", qb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
